// File: rtl/axi_burst_write_master.sv
// axi_burst_write_master
// Takes one write command (base address + beat count), splits it into AXI4
// INCR bursts of at most MAX_BURST beats that never cross a 4 KB boundary,
// streams the beats from a show-ahead packet buffer, keeps up to
// MAX_OUTSTANDING bursts in flight and folds every B response into a single
// wr_done / wr_err result.
module axi_burst_write_master #(
   parameter int AXI_ADDR_W      = 40,
   parameter int AXI_DATA_W      = 512,
   parameter int AXI_ID_W        = 4,
   parameter int AXI_ID          = 1,
   parameter int LEN_W           = 16,
   parameter int MAX_BURST       = 16,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   // command side
   input  logic                    cmd_vld,
   output logic                    cmd_rdy,
   input  logic [AXI_ADDR_W-1:0]   cmd_addr,
   input  logic [LEN_W-1:0]        cmd_len,
   output logic                    wr_done,
   output logic                    wr_err,
   // packet buffer read side
   input  logic                    pb_empty,
   input  logic [AXI_DATA_W-1:0]   data_flit,
   output logic                    pb_rd_en,
   // AXI write address channel
   output logic [AXI_ID_W-1:0]     axi_awid,
   output logic [AXI_ADDR_W-1:0]   axi_awaddr,
   output logic [7:0]              axi_awlen,
   output logic [2:0]              axi_awsize,
   output logic [1:0]              axi_awburst,
   output logic [3:0]              axi_awcache,
   output logic                    axi_awvld,
   input  logic                    axi_awrdy,
   // AXI write data channel
   output logic [AXI_DATA_W-1:0]   axi_wdata,
   output logic [AXI_DATA_W/8-1:0] axi_wstrb,
   output logic                    axi_wlast,
   output logic                    axi_wvld,
   input  logic                    axi_wrdy,
   // AXI write response channel
   input  logic [1:0]              axi_bresp,
   input  logic                    axi_bvld,
   output logic                    axi_brdy
);

   localparam int BYTES = AXI_DATA_W / 8;
   localparam int SIZE  = $clog2(BYTES);
   localparam int RW    = LEN_W + 1;                      // remaining-beats width
   localparam int CW    = (RW > 13) ? RW : 13;            // burst-size arithmetic width
   localparam int OW    = $clog2(MAX_OUTSTANDING + 1);    // outstanding / fifo count width
   localparam int PW    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t                state, state_nxt;
   logic [AXI_ADDR_W-1:0] addr_q;
   logic [RW-1:0]         remaining_q;
   logic [OW-1:0]         outstanding_q;
   logic                  err_q;

   logic [CW-1:0]         to_boundary;
   logic [CW-1:0]         beats;
   logic [8:0]            burst_beats;
   logic                  cmd_hs, aw_hs, w_hs, b_hs;
   logic                  issue_ok, drain_done;

   // W-length FIFO: one entry (awlen) per issued burst
   logic [7:0]            fifo_mem [MAX_OUTSTANDING];
   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic [OW-1:0]         fifo_cnt;
   logic                  fifo_nonempty;
   logic                  fifo_push, fifo_pop;
   logic [7:0]            beat_cnt;

   logic                  unused_bits;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
   endfunction

   assign cmd_hs      = cmd_vld & cmd_rdy;
   assign aw_hs       = axi_awvld & axi_awrdy;
   assign w_hs        = axi_wvld & axi_wrdy;
   assign b_hs        = axi_bvld & axi_brdy;
   assign burst_beats = {1'b0, axi_awlen} + 9'd1;

   assign fifo_nonempty = (fifo_cnt != '0);
   assign fifo_push     = aw_hs;
   assign fifo_pop      = w_hs & axi_wlast;

   // constant AW attributes and combinational W / B channel controls
   assign axi_awid    = AXI_ID_W'(AXI_ID);
   assign axi_awsize  = 3'(SIZE);
   assign axi_awburst = 2'b01;
   assign axi_awcache = 4'b0010;
   assign axi_wdata   = data_flit;
   assign axi_wstrb   = '1;
   assign axi_wvld    = ~pb_empty & fifo_nonempty;
   assign axi_wlast   = fifo_nonempty & (beat_cnt == fifo_mem[rd_ptr]);
   assign pb_rd_en    = w_hs;
   assign axi_brdy    = (outstanding_q != '0);

   // low address bits are forced to zero and bresp[0] carries no meaning here
   assign unused_bits = ^{cmd_addr[SIZE-1:0], axi_bresp[0]};

   // Next burst size: min(remaining, MAX_BURST, beats left before the 4 KB line)
   always_comb begin
      to_boundary = CW'((13'h1000 - {1'b0, addr_q[11:0]}) >> SIZE);
      beats       = CW'(remaining_q);
      if (beats > CW'(MAX_BURST)) beats = CW'(MAX_BURST);
      if (beats > to_boundary)    beats = to_boundary;
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // FSM next-state and issue/drain decisions
   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_nxt  = state;
      issue_ok   = 1'b0;
      drain_done = 1'b0;
      unique case (state)
         IDLE: begin
            if (cmd_hs) state_nxt = ISSUE;
         end
         ISSUE: begin
            issue_ok = ~axi_awvld & (outstanding_q < OW'(MAX_OUTSTANDING));
            if (aw_hs && (remaining_q == RW'(burst_beats))) state_nxt = DRAIN;
         end
         DRAIN: begin
            drain_done = (outstanding_q == '0) & ~fifo_nonempty;
            if (drain_done) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Command, AW registers, outstanding count, sticky error and done pulse
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every reader sees pre-edge values.
      if (rst) begin
         cmd_rdy       <= 1'b0;
         wr_done       <= 1'b0;
         wr_err        <= 1'b0;
         addr_q        <= '0;
         remaining_q   <= '0;
         outstanding_q <= '0;
         err_q         <= 1'b0;
         axi_awvld     <= 1'b0;
         axi_awaddr    <= '0;
         axi_awlen     <= '0;
      end else begin
         cmd_rdy <= (state_nxt == IDLE);
         wr_done <= drain_done;
         wr_err  <= drain_done & err_q;

         if (cmd_hs) begin
            addr_q      <= {cmd_addr[AXI_ADDR_W-1:SIZE], {SIZE{1'b0}}};
            remaining_q <= {1'b0, cmd_len} + RW'(1);
            err_q       <= 1'b0;
         end

         // address/len only load while awvld is low, so they hold during a stall
         if (issue_ok) begin
            axi_awvld  <= 1'b1;
            axi_awaddr <= addr_q;
            axi_awlen  <= 8'(beats - CW'(1));
         end

         if (aw_hs) begin
            axi_awvld   <= 1'b0;
            addr_q      <= addr_q + (AXI_ADDR_W'(burst_beats) << SIZE);
            remaining_q <= remaining_q - RW'(burst_beats);
         end

         // simultaneous AW and B handshakes cancel out
         outstanding_q <= outstanding_q + OW'(aw_hs) - OW'(b_hs);

         if (b_hs && axi_bresp[1]) err_q <= 1'b1;
      end
   end

   // W-length FIFO storage
   always_ff @(posedge clk) begin
      // NOTE: storage is not reset; the pointers and count alone say which entries are valid.
      if (fifo_push) fifo_mem[wr_ptr] <= axi_awlen;
   end

   // W-length FIFO pointers and beat counter against the head entry
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
         beat_cnt <= '0;
      end else begin
         if (fifo_push) wr_ptr <= ptr_inc(wr_ptr);
         if (fifo_pop)  rd_ptr <= ptr_inc(rd_ptr);
         fifo_cnt <= fifo_cnt + OW'(fifo_push) - OW'(fifo_pop);
         if (w_hs) beat_cnt <= axi_wlast ? 8'd0 : beat_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_axi_burst_write_master.sv
// Directed bench for axi_burst_write_master: AXI slave + packet-buffer model,
// AW and W scoreboards filled when each command is issued, done/err tracking.
module tb_axi_burst_write_master;

   localparam int AW    = 40;
   localparam int DW    = 512;
   localparam int IW    = 4;
   localparam int LW    = 16;
   localparam int BYTES = DW / 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              cmd_vld = 1'b0;
   logic              cmd_rdy;
   logic [AW-1:0]     cmd_addr = '0;
   logic [LW-1:0]     cmd_len = '0;
   logic              wr_done, wr_err;
   logic              pb_empty;
   logic [DW-1:0]     data_flit;
   logic              pb_rd_en;
   logic [IW-1:0]     axi_awid;
   logic [AW-1:0]     axi_awaddr;
   logic [7:0]        axi_awlen;
   logic [2:0]        axi_awsize;
   logic [1:0]        axi_awburst;
   logic [3:0]        axi_awcache;
   logic              axi_awvld;
   logic              axi_awrdy = 1'b1;
   logic [DW-1:0]     axi_wdata;
   logic [BYTES-1:0]  axi_wstrb;
   logic              axi_wlast, axi_wvld;
   logic              axi_wrdy = 1'b1;
   logic [1:0]        axi_bresp = 2'b00;
   logic              axi_bvld = 1'b0;
   logic              axi_brdy;

   int n_checks = 0;
   int n_errors = 0;

   // stimulus knobs (written by the initial block only)
   int  pb_total  = 0;
   bit  aw_rand   = 0;
   bit  w_rand    = 0;
   bit  pb_toggle = 0;
   int  b_allowed = 1 << 30;
   int  bad_b     = -1;

   // slave / packet-buffer model state (written by the slave block only)
   int  pb_idx  = 0;
   int  b_pend  = 0;
   int  b_count = 0;
   int  cyc     = 0;
   bit  pb_gap  = 0;
   logic rst_s;

   // monitor state (written by the monitor block only)
   int  aw_cnt   = 0;
   int  done_cnt = 0;
   logic done_err = 1'b0;
   bit  aw_f = 0, w_f = 0, wl_f = 0, b_f = 0;
   bit  aw_stall = 0, w_stall = 0;
   logic [AW-1:0] prev_awaddr;
   logic [7:0]    prev_awlen;
   logic [DW-1:0] prev_wdata;
   logic          prev_wlast;

   // scoreboards
   logic [AW+7:0] exp_aw_q [$];   // {awlen, awaddr}
   logic [DW:0]   exp_w_q  [$];   // {wlast, wdata}

   always #5 clk = ~clk;

   axi_burst_write_master dut (
      .clk(clk), .rst(rst),
      .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_done(wr_done), .wr_err(wr_err),
      .pb_empty(pb_empty), .data_flit(data_flit), .pb_rd_en(pb_rd_en),
      .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
      .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awcache(axi_awcache),
      .axi_awvld(axi_awvld), .axi_awrdy(axi_awrdy),
      .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
      .axi_wvld(axi_wvld), .axi_wrdy(axi_wrdy),
      .axi_bresp(axi_bresp), .axi_bvld(axi_bvld), .axi_brdy(axi_brdy)
   );

   // distinct, index-derived packet-buffer contents
   function automatic logic [DW-1:0] flit(input int i);
      logic [DW-1:0] v;
      for (int k = 0; k < DW / 32; k++)
         v[k*32 +: 32] = 32'(i) * 32'h9E37_79B1 + 32'(k) * 32'h0101_0101 + 32'h5A5A_0000;
      return v;
   endfunction

   assign data_flit = flit(pb_idx);
   assign pb_empty  = (pb_idx >= pb_total) || pb_gap;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Monitor: sample between edges, score handshakes that the next posedge completes
   always @(negedge clk) begin
      aw_f = axi_awvld & axi_awrdy;
      w_f  = axi_wvld & axi_wrdy;
      wl_f = w_f & axi_wlast;
      b_f  = axi_bvld & axi_brdy;

      if (aw_stall) begin
         check("aw_hold_vld", axi_awvld, 1'b1);
         check("aw_hold_addr", axi_awaddr, prev_awaddr);
         check("aw_hold_len", axi_awlen, prev_awlen);
      end
      if (aw_f) begin
         aw_cnt++;
         check("aw_pending", exp_aw_q.size() > 0, 1'b1);
         if (exp_aw_q.size() > 0) begin
            logic [AW+7:0] e;
            e = exp_aw_q.pop_front();
            check("awaddr", axi_awaddr, e[AW-1:0]);
            check("awlen", axi_awlen, e[AW+7:AW]);
         end
         check("awid", axi_awid, 4'd1);
         check("awsize", axi_awsize, 3'd6);
         check("awburst", axi_awburst, 2'b01);
         check("awcache", axi_awcache, 4'b0010);
      end

      if (w_stall && axi_wvld) begin
         check("w_hold_data", axi_wdata, prev_wdata);
         check("w_hold_last", axi_wlast, prev_wlast);
      end
      if (w_f) begin
         check("w_pending", exp_w_q.size() > 0, 1'b1);
         if (exp_w_q.size() > 0) begin
            logic [DW:0] e;
            e = exp_w_q.pop_front();
            check("wdata", axi_wdata, e[DW-1:0]);
            check("wlast", axi_wlast, e[DW]);
         end
         check("wstrb", axi_wstrb, {BYTES{1'b1}});
         check("pb_rd_en", pb_rd_en, 1'b1);
      end else begin
         check("pb_rd_idle", pb_rd_en, 1'b0);
      end

      if (wr_done) begin
         done_cnt++;
         done_err = wr_err;
      end else begin
         check("err_idle", wr_err, 1'b0);
      end

      aw_stall    = axi_awvld & ~axi_awrdy;
      prev_awaddr = axi_awaddr;
      prev_awlen  = axi_awlen;
      w_stall     = axi_wvld & ~axi_wrdy;
      prev_wdata  = axi_wdata;
      prev_wlast  = axi_wlast;
   end

   // AXI slave and packet-buffer model, driven just after each posedge
   always @(posedge clk) begin
      rst_s = rst;
      #1;
      if (w_f) pb_idx++;
      if (rst_s) begin
         b_pend = 0;
      end else begin
         if (wl_f) b_pend++;
         if (b_f) begin
            b_pend--;
            b_count++;
         end
      end
      cyc++;
      axi_awrdy = aw_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      axi_wrdy  = w_rand  ? 1'($urandom_range(0, 1)) : 1'b1;
      pb_gap    = pb_toggle && (((cyc / 3) % 2) == 1);
      axi_bvld  = (b_pend > 0) && (b_count < b_allowed);
      axi_bresp = (b_count == bad_b) ? 2'b10 : 2'b00;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Push the expected bursts/beats for a command, then hand it to the DUT
   task automatic send_cmd(input logic [AW-1:0] addr, input int len);
      logic [AW-1:0] a;
      int rem, b, k, room, n;
      logic ok;
      a   = {addr[AW-1:6], 6'b0};
      rem = len + 1;
      k   = pb_total;
      while (rem > 0) begin
         room = (4096 - int'(a[11:0])) / BYTES;
         b = (rem > 16) ? 16 : rem;
         if (b > room) b = room;
         exp_aw_q.push_back({8'(b - 1), a});
         for (int j = 0; j < b; j++) begin
            exp_w_q.push_back({(j == b - 1), flit(k)});
            k++;
         end
         a   = a + AW'(b * BYTES);
         rem = rem - b;
      end
      pb_total = k;
      cmd_addr = addr;
      cmd_len  = LW'(len);
      cmd_vld  = 1'b1;
      ok = 1'b0;
      n  = 0;
      while (!ok && n < 200) begin
         @(negedge clk);
         if (cmd_rdy) ok = 1'b1;
         n++;
      end
      check("cmd_accept", ok, 1'b1);
      @(posedge clk);
      #1;
      cmd_vld = 1'b0;
   endtask

   task automatic wait_done(input string tag, input logic exp_err, input int budget);
      int start, n;
      start = done_cnt;
      n = 0;
      while (done_cnt == start && n < budget) begin
         tick(1);
         n++;
      end
      check({tag, "_done"}, done_cnt != start, 1'b1);
      check({tag, "_err"}, done_err, exp_err);
      tick(5);
      check({tag, "_one_pulse"}, done_cnt - start, 1);
      check({tag, "_aw_left"}, exp_aw_q.size(), 0);
      check({tag, "_w_left"}, exp_w_q.size(), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cmd_rdy"}, cmd_rdy, 1'b0);
      check({tag, "_wr_done"}, wr_done, 1'b0);
      check({tag, "_wr_err"}, wr_err, 1'b0);
      check({tag, "_awvld"}, axi_awvld, 1'b0);
      check({tag, "_wvld"}, axi_wvld, 1'b0);
      check({tag, "_wlast"}, axi_wlast, 1'b0);
      check({tag, "_pb_rd_en"}, pb_rd_en, 1'b0);
      check({tag, "_brdy"}, axi_brdy, 1'b0);
      check({tag, "_awaddr"}, axi_awaddr, 40'd0);
      check({tag, "_awlen"}, axi_awlen, 8'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int base, idx0, n;

      // reset state
      rst = 1'b1;
      tick(3);
      check_reset_outputs("reset");
      rst = 1'b0;
      tick(2);
      check("idle_cmd_rdy", cmd_rdy, 1'b1);

      // three bursts: 0x1000/15, 0x1400/15, 0x1800/7
      base = aw_cnt;
      idx0 = pb_idx;
      send_cmd(40'h1000, 39);
      wait_done("basic", 1'b0, 500);
      check("basic_aw_count", aw_cnt - base, 3);
      check("basic_pb_pops", pb_idx - idx0, 40);

      // 4 KB crossing with ignored low address bits
      base = aw_cnt;
      send_cmd(40'h1F9F, 3);
      wait_done("cross4k", 1'b0, 200);
      check("cross4k_aw_count", aw_cnt - base, 2);

      // wrap at the top of the address space
      send_cmd(40'hFF_FFFF_FFC0, 2);
      wait_done("wrap", 1'b0, 200);

      // outstanding limit: B held back
      b_allowed = b_count;
      base = aw_cnt;
      send_cmd(40'h0, 79);
      tick(150);
      check("ost_aw_count", aw_cnt - base, 4);
      check("ost_awvld_low", axi_awvld, 1'b0);
      check("ost_brdy", axi_brdy, 1'b1);
      b_allowed = b_count + 1;
      tick(40);
      check("ost_one_more", aw_cnt - base, 5);
      b_allowed = 1 << 30;
      wait_done("ost", 1'b0, 500);

      // error on the second of three B responses, then a clean command
      bad_b = b_count + 1;
      send_cmd(40'h8000, 39);
      wait_done("slverr", 1'b1, 500);
      bad_b = -1;
      send_cmd(40'h9000, 39);
      wait_done("okay_after_err", 1'b0, 500);

      // backpressure on AW, W and packet buffer
      aw_rand   = 1;
      w_rand    = 1;
      pb_toggle = 1;
      idx0 = pb_idx;
      send_cmd(40'h3040, 50);
      wait_done("bp", 1'b0, 3000);
      check("bp_pb_pops", pb_idx - idx0, 51);
      aw_rand   = 0;
      w_rand    = 0;
      pb_toggle = 0;
      tick(3);

      // reset one cycle after the second AW handshake
      base = aw_cnt;
      send_cmd(40'h6000, 63);
      n = 0;
      while (aw_cnt < base + 2 && n < 100) begin
         tick(1);
         n++;
      end
      check("rst_second_aw", aw_cnt - base >= 2, 1'b1);
      base = done_cnt;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_reset_outputs("midrst");
      #1;
      rst = 1'b0;
      exp_aw_q.delete();
      exp_w_q.delete();
      pb_total = pb_idx;
      tick(20);
      check("midrst_no_done", done_cnt - base, 0);
      check("midrst_cmd_rdy", cmd_rdy, 1'b1);
      send_cmd(40'h7000, 20);
      wait_done("after_rst", 1'b0, 500);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
